// File: rtl/tablero_pkg.sv
// Shared types for the tic-tac-toe board/turn datapath: cell encoding, FSM states, one-hot helper.
// Pure declarations; no timing or flow control of its own.
package tablero_pkg;

  localparam int NUM_CELDAS = 9;

  typedef enum logic [1:0] {
    VACIA = 2'b00,
    J1    = 2'b01,
    J2    = 2'b10
  } celda_t;

  typedef enum logic [2:0] {
    ESPERA_J1,
    VALIDA_J1,
    ESPERA_J2,
    VALIDA_J2,
    FIN
  } estado_t;

  function automatic logic es_one_hot(input logic [NUM_CELDAS-1:0] v);
    return (v != '0) && ((v & (v - {{(NUM_CELDAS-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/temporizador_turno.sv
// Idle-turn counter: clear/enable, combinational terminal-count pulse at TIEMPO_TURNO-1.
// Wraps itself back to zero on terminal count; no backpressure.
module temporizador_turno #(
  parameter int TIEMPO_TURNO = 500,
  parameter int ANCHO_TIMER  = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic limpiar,
  input  logic habilitar,
  output logic fin_cuenta
);

  localparam logic [ANCHO_TIMER-1:0] LIMITE = ANCHO_TIMER'(TIEMPO_TURNO - 1);
  localparam logic [ANCHO_TIMER-1:0] UNO    = ANCHO_TIMER'(1);

  logic [ANCHO_TIMER-1:0] cuenta_q, cuenta_d;

  assign fin_cuenta = habilitar && (cuenta_q == LIMITE);

  always_comb begin
    cuenta_d = cuenta_q;
    if (limpiar || fin_cuenta) begin
      cuenta_d = '0;
    end else if (habilitar) begin
      cuenta_d = cuenta_q + UNO;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/control_turnos_tablero.sv
// Board register and turn sequencer: captures a selection, validates it for one cycle, then commits or rejects.
// confirmar -> board visible 2 cycles later; confirmar outside ESPERA is dropped, never queued.
module control_turnos_tablero
  import tablero_pkg::*;
#(
  parameter int TIEMPO_TURNO = 500,
  parameter int ANCHO_TIMER  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nuevo_juego,
  input  logic       confirmar,
  input  logic [8:0] seleccion,
  input  logic       jugadaIlegal,
  input  logic       hay_ganador,
  output logic [1:0] pos0,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [8:0] jugador1Habilitado,
  output logic [8:0] jugador2Habilitado,
  output logic       turno,
  output logic       jugada_rechazada,
  output logic       tiempo_agotado,
  output logic       juego_terminado,
  output logic [3:0] num_jugadas
);

  estado_t                 estado_q, estado_d;
  logic [NUM_CELDAS-1:0]   sel_q, sel_d;
  logic [NUM_CELDAS-1:0]   hab1_q, hab1_d, hab2_q, hab2_d;
  celda_t                  tablero_q [NUM_CELDAS];
  celda_t                  tablero_d [NUM_CELDAS];
  logic [3:0]              num_q, num_d;
  logic                    turno_q, turno_d;
  logic                    rechazada_q, rechazada_d;
  logic                    agotado_q, agotado_d;
  logic                    en_espera, habilitar_timer, fin_cuenta;

  // Timer only runs on a genuinely idle ESPERA cycle; kept off the next-state block to avoid a comb loop.
  assign en_espera       = (estado_q == ESPERA_J1) || (estado_q == ESPERA_J2);
  assign habilitar_timer = en_espera && !hay_ganador && (num_q != 4'd9) && !confirmar && !nuevo_juego;

  temporizador_turno #(
    .TIEMPO_TURNO(TIEMPO_TURNO),
    .ANCHO_TIMER (ANCHO_TIMER)
  ) u_temporizador (
    .clk       (clk),
    .rst       (rst),
    .limpiar   (!habilitar_timer),
    .habilitar (habilitar_timer),
    .fin_cuenta(fin_cuenta)
  );

  always_comb begin
    estado_d    = estado_q;
    sel_d       = sel_q;
    hab1_d      = '0;
    hab2_d      = '0;
    tablero_d   = tablero_q;
    num_d       = num_q;
    turno_d     = turno_q;
    rechazada_d = 1'b0;
    agotado_d   = 1'b0;

    case (estado_q)
      ESPERA_J1, ESPERA_J2: begin
        if (hay_ganador || (num_q == 4'd9)) begin
          estado_d = FIN;
        end else if (confirmar) begin
          sel_d = seleccion;
          if (estado_q == ESPERA_J1) begin
            estado_d = VALIDA_J1;
            hab1_d   = seleccion;
          end else begin
            estado_d = VALIDA_J2;
            hab2_d   = seleccion;
          end
        end else if (fin_cuenta) begin
          agotado_d = 1'b1;
          turno_d   = ~turno_q;
          estado_d  = (estado_q == ESPERA_J1) ? ESPERA_J2 : ESPERA_J1;
        end
      end
      VALIDA_J1, VALIDA_J2: begin
        if (jugadaIlegal || !es_one_hot(sel_q)) begin
          rechazada_d = 1'b1;
          estado_d    = (estado_q == VALIDA_J1) ? ESPERA_J1 : ESPERA_J2;
        end else begin
          for (int i = 0; i < NUM_CELDAS; i++) begin
            if (sel_q[i]) tablero_d[i] = (estado_q == VALIDA_J1) ? J1 : J2;
          end
          if (num_q != 4'd9) num_d = num_q + 4'd1;
          turno_d  = ~turno_q;
          estado_d = (estado_q == VALIDA_J1) ? ESPERA_J2 : ESPERA_J1;
        end
      end
      FIN: ;
      default: estado_d = ESPERA_J1;
    endcase

    if (nuevo_juego) begin
      estado_d    = ESPERA_J1;
      sel_d       = '0;
      hab1_d      = '0;
      hab2_d      = '0;
      num_d       = '0;
      turno_d     = 1'b0;
      rechazada_d = 1'b0;
      agotado_d   = 1'b0;
      for (int i = 0; i < NUM_CELDAS; i++) tablero_d[i] = VACIA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= ESPERA_J1;
      sel_q       <= '0;
      hab1_q      <= '0;
      hab2_q      <= '0;
      num_q       <= '0;
      turno_q     <= 1'b0;
      rechazada_q <= 1'b0;
      agotado_q   <= 1'b0;
      for (int i = 0; i < NUM_CELDAS; i++) tablero_q[i] <= VACIA;
    end else begin
      estado_q    <= estado_d;
      sel_q       <= sel_d;
      hab1_q      <= hab1_d;
      hab2_q      <= hab2_d;
      num_q       <= num_d;
      turno_q     <= turno_d;
      rechazada_q <= rechazada_d;
      agotado_q   <= agotado_d;
      tablero_q   <= tablero_d;
    end
  end

  assign pos0 = tablero_q[0];
  assign pos1 = tablero_q[1];
  assign pos2 = tablero_q[2];
  assign pos3 = tablero_q[3];
  assign pos4 = tablero_q[4];
  assign pos5 = tablero_q[5];
  assign pos6 = tablero_q[6];
  assign pos7 = tablero_q[7];
  assign pos8 = tablero_q[8];

  assign jugador1Habilitado = hab1_q;
  assign jugador2Habilitado = hab2_q;
  assign turno              = turno_q;
  assign jugada_rechazada   = rechazada_q;
  assign tiempo_agotado     = agotado_q;
  assign juego_terminado    = (estado_q == FIN);
  assign num_jugadas        = num_q;

endmodule

// File: tb/tb_control_turnos_tablero.sv
// Bench for control_turnos_tablero: closes the loop with an illegal-move detector and win checker,
// compares every cycle against a move-level game model, plus directed literal checks.
module tb_control_turnos_tablero;

  localparam int T = 8;
  localparam int LIN [0:7][0:2] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                     '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic       clk = 1'b0;
  logic       rst, nuevo_juego, confirmar;
  logic [8:0] seleccion;
  logic       jugadaIlegal, hay_ganador;
  logic [1:0] pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8;
  logic [8:0] jugador1Habilitado, jugador2Habilitado;
  logic       turno, jugada_rechazada, tiempo_agotado, juego_terminado;
  logic [3:0] num_jugadas;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_turnos_tablero #(.TIEMPO_TURNO(T), .ANCHO_TIMER(4)) dut (
    .clk(clk), .rst(rst), .nuevo_juego(nuevo_juego), .confirmar(confirmar),
    .seleccion(seleccion), .jugadaIlegal(jugadaIlegal), .hay_ganador(hay_ganador),
    .pos0(pos0), .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4),
    .pos5(pos5), .pos6(pos6), .pos7(pos7), .pos8(pos8),
    .jugador1Habilitado(jugador1Habilitado), .jugador2Habilitado(jugador2Habilitado),
    .turno(turno), .jugada_rechazada(jugada_rechazada), .tiempo_agotado(tiempo_agotado),
    .juego_terminado(juego_terminado), .num_jugadas(num_jugadas)
  );

  logic [1:0]  pos_v [9];
  logic [17:0] tab_vec;
  assign pos_v[0] = pos0; assign pos_v[1] = pos1; assign pos_v[2] = pos2;
  assign pos_v[3] = pos3; assign pos_v[4] = pos4; assign pos_v[5] = pos5;
  assign pos_v[6] = pos6; assign pos_v[7] = pos7; assign pos_v[8] = pos8;
  assign tab_vec  = {pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1, pos0};

  // Detector and win checker in the loop, driven by the DUT's own board.
  always_comb begin
    jugadaIlegal = 1'b0;
    for (int i = 0; i < 9; i++)
      if ((jugador1Habilitado[i] || jugador2Habilitado[i]) && pos_v[i] != 2'b00) jugadaIlegal = 1'b1;
  end

  always_comb begin
    hay_ganador = 1'b0;
    for (int k = 0; k < 8; k++)
      if (pos_v[LIN[k][0]] != 2'b00 && pos_v[LIN[k][0]] == pos_v[LIN[k][1]] &&
          pos_v[LIN[k][0]] == pos_v[LIN[k][2]]) hay_ganador = 1'b1;
  end

  // Game model: mode 0 = waiting for a move, 1 = move being judged, 2 = game over.
  int         m_tab [9];
  int         m_turn, m_moves, m_mode, m_idle;
  logic [8:0] m_held;
  bit         m_rej, m_to;

  function automatic bit m_ganador();
    for (int k = 0; k < 8; k++)
      if (m_tab[LIN[k][0]] != 0 && m_tab[LIN[k][0]] == m_tab[LIN[k][1]] &&
          m_tab[LIN[k][0]] == m_tab[LIN[k][2]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int celda(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic m_limpiar();
    for (int i = 0; i < 9; i++) m_tab[i] <= 0;
    m_turn <= 0; m_moves <= 0; m_mode <= 0; m_idle <= 0;
    m_held <= '0; m_rej <= 1'b0; m_to <= 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || nuevo_juego) begin
      m_limpiar();
    end else begin
      m_rej <= 1'b0;
      m_to  <= 1'b0;
      if (m_mode == 0) begin
        if (m_ganador() || m_moves == 9) begin
          m_mode <= 2;
        end else if (confirmar) begin
          m_held <= seleccion;
          m_mode <= 1;
          m_idle <= 0;
        end else if (m_idle == T - 1) begin
          m_to   <= 1'b1;
          m_turn <= 1 - m_turn;
          m_idle <= 0;
        end else begin
          m_idle <= m_idle + 1;
        end
      end else if (m_mode == 1) begin
        if ($countones(m_held) == 1 && m_tab[celda(m_held)] == 0) begin
          m_tab[celda(m_held)] <= m_turn + 1;
          m_moves <= m_moves + 1;
          m_turn  <= 1 - m_turn;
        end else begin
          m_rej <= 1'b1;
        end
        m_mode <= 0;
        m_idle <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [17:0] exp_tab;
    for (int i = 0; i < 9; i++) exp_tab[2*i +: 2] = 2'(m_tab[i]);
    chk("m_tablero", 32'(tab_vec), 32'(exp_tab));
    chk("m_hab1", 32'(jugador1Habilitado), (m_mode == 1 && m_turn == 0) ? 32'(m_held) : 32'd0);
    chk("m_hab2", 32'(jugador2Habilitado), (m_mode == 1 && m_turn == 1) ? 32'(m_held) : 32'd0);
    chk("m_turno", 32'(turno), 32'(m_turn));
    chk("m_rechazada", 32'(jugada_rechazada), 32'(m_rej));
    chk("m_agotado", 32'(tiempo_agotado), 32'(m_to));
    chk("m_terminado", 32'(juego_terminado), 32'(m_mode == 2));
    chk("m_num", 32'(num_jugadas), 32'(m_moves));
  end

  task automatic jugar(input logic [8:0] s);
    @(negedge clk);
    seleccion = s;
    confirmar = 1'b1;
    @(negedge clk);
    confirmar = 1'b0;
  endtask

  task automatic reiniciar();
    @(negedge clk);
    nuevo_juego = 1'b1;
    @(negedge clk);
    nuevo_juego = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int seq_win  [5] = '{0, 3, 1, 4, 2};
  int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    rst = 1'b1; nuevo_juego = 1'b0; confirmar = 1'b0; seleccion = '0;
    repeat (3) @(negedge clk);
    chk("rst_tablero", 32'(tab_vec), 32'd0);
    chk("rst_turno", 32'(turno), 32'd0);
    chk("rst_num", 32'(num_jugadas), 32'd0);
    chk("rst_terminado", 32'(juego_terminado), 32'd0);
    rst = 1'b0;

    jugar(9'h010);
    chk("legal_hab1", 32'(jugador1Habilitado), 32'h010);
    chk("legal_hab2", 32'(jugador2Habilitado), 32'h000);
    @(negedge clk);
    chk("legal_pos4", 32'(pos4), 32'd1);
    chk("legal_turno", 32'(turno), 32'd1);
    chk("legal_num", 32'(num_jugadas), 32'd1);

    jugar(9'h010);
    chk("ocupada_hab2", 32'(jugador2Habilitado), 32'h010);
    @(negedge clk);
    chk("ocupada_rech", 32'(jugada_rechazada), 32'd1);
    chk("ocupada_pos4", 32'(pos4), 32'd1);
    chk("ocupada_turno", 32'(turno), 32'd1);

    jugar(9'h003);
    @(negedge clk);
    chk("multi_rech", 32'(jugada_rechazada), 32'd1);
    chk("multi_num", 32'(num_jugadas), 32'd1);
    jugar(9'h000);
    @(negedge clk);
    chk("cero_rech", 32'(jugada_rechazada), 32'd1);
    chk("cero_tablero", 32'(tab_vec), 32'h00100);

    repeat (7) @(negedge clk);
    chk("timeout_antes", 32'(tiempo_agotado), 32'd0);
    chk("timeout_turno_antes", 32'(turno), 32'd1);
    @(negedge clk);
    chk("timeout_pulso", 32'(tiempo_agotado), 32'd1);
    chk("timeout_turno", 32'(turno), 32'd0);
    chk("timeout_tablero", 32'(tab_vec), 32'h00100);

    reiniciar();
    chk("nuevo_tablero", 32'(tab_vec), 32'd0);
    foreach (seq_win[i]) jugar(9'b1 << seq_win[i]);
    repeat (2) @(negedge clk);
    chk("gana_terminado", 32'(juego_terminado), 32'd1);
    chk("gana_num", 32'(num_jugadas), 32'd5);
    chk("gana_tablero", 32'(tab_vec), 32'h00295);
    jugar(9'h100);
    @(negedge clk);
    chk("fin_ignora_num", 32'(num_jugadas), 32'd5);
    chk("fin_ignora_tablero", 32'(tab_vec), 32'h00295);

    reiniciar();
    chk("fin_nuevo_terminado", 32'(juego_terminado), 32'd0);
    chk("fin_nuevo_num", 32'(num_jugadas), 32'd0);
    chk("fin_nuevo_tablero", 32'(tab_vec), 32'd0);

    foreach (seq_draw[i]) jugar(9'b1 << seq_draw[i]);
    repeat (2) @(negedge clk);
    chk("empate_terminado", 32'(juego_terminado), 32'd1);
    chk("empate_num", 32'(num_jugadas), 32'd9);
    chk("empate_tablero", 32'(tab_vec), 32'h16A59);

    reiniciar();
    @(negedge clk);
    seleccion = 9'h010;
    confirmar = 1'b1;
    @(posedge clk);
    #1;
    confirmar = 1'b0;
    chk("valida_hab1", 32'(jugador1Habilitado), 32'h010);
    rst = 1'b1;
    #1;
    chk("rst_async_hab1", 32'(jugador1Habilitado), 32'd0);
    @(negedge clk);
    chk("rst_async_pos4", 32'(pos4), 32'd0);
    chk("rst_async_num", 32'(num_jugadas), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
